// File: rtl/thirtytwo_bit_divider.sv
`default_nettype none
// ============================================================================
// Module   : thirtytwo_bit_divider
// Purpose  : Multicycle radix-2 restoring divider. One operand pair is accepted
//            per start pulse. The core runs one quotient bit per clock. It
//            returns the quotient, the remainder and an exception flag, and
//            marks completion with a one-cycle ready pulse.
// Ports    : clock          - rising-edge clock
//            reset_n        - asynchronous active-low reset
//            ctrl_div       - start pulse, sampled only while idle
//            signed_op      - 1 = two's-complement divide, 0 = unsigned
//            data_dividend  - dividend, sampled with ctrl_div
//            data_divisor   - divisor, sampled with ctrl_div
//            data_quotient  - quotient of the last completed operation
//            data_remainder - remainder of the last completed operation
//            data_exception - 1 = last operation faulted
//            data_resultRDY - one-cycle completion pulse
//            busy           - high while an operation is in flight
// Options  : DIV_OVERFLOW_EXC_EN - when defined, signed MIN / -1 faults with
//            zero-divide timing instead of wrapping to MIN.
// Revision : 1.0 - initial release
// ============================================================================
module thirtytwo_bit_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] data_dividend,
  input  logic [WIDTH-1:0] data_divisor,
  output logic [WIDTH-1:0] data_quotient,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] q_reg;     // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] acc_reg;   // partial remainder
  logic [WIDTH-1:0] div_reg;   // divisor magnitude
  logic [CW-1:0]    cnt;
  logic             neg_q;     // operand signs differ in a signed op
  logic             neg_r;     // signed op with a negative dividend
  logic             err;       // operation completes through the fault path

  // Operand preparation. The magnitude of the most negative value is the
  // same bit pattern read as unsigned, so plain negation is sufficient.
  logic [WIDTH-1:0] abs_dividend, abs_divisor;
  logic             start_err, ovf;

  assign abs_dividend = (signed_op && data_dividend[WIDTH-1]) ? -data_dividend : data_dividend;
  assign abs_divisor  = (signed_op && data_divisor[WIDTH-1])  ? -data_divisor  : data_divisor;

`ifdef DIV_OVERFLOW_EXC_EN
  assign ovf = signed_op && (data_dividend == {1'b1, {(WIDTH-1){1'b0}}})
                         && (data_divisor == {WIDTH{1'b1}});
`else
  assign ovf = 1'b0;
`endif

  assign start_err = (data_divisor == '0) || ovf;

  // One restoring step. The shifted partial remainder needs WIDTH+1 bits.
  // When the trial subtraction succeeds the difference is below the divisor,
  // so its low WIDTH bits are the complete new partial remainder.
  logic [WIDTH:0]   acc_sh;
  logic [WIDTH-1:0] diff;
  logic             trial_ok;

  assign acc_sh   = {acc_reg, q_reg[WIDTH-1]};
  assign trial_ok = (acc_sh >= {1'b0, div_reg});
  assign diff     = acc_sh[WIDTH-1:0] - div_reg;

  assign busy = (state != IDLE);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A faulting operation spends exactly one cycle in RUN,
  // so its result appears two edges after the start pulse is sampled.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ctrl_div) state_nxt = RUN;
      RUN:     if (err || (cnt == LAST_ITER)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_reg          <= '0;
      acc_reg        <= '0;
      div_reg        <= '0;
      cnt            <= '0;
      neg_q          <= 1'b0;
      neg_r          <= 1'b0;
      err            <= 1'b0;
      data_quotient  <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl_div) begin
            q_reg   <= abs_dividend;
            acc_reg <= '0;
            div_reg <= abs_divisor;
            cnt     <= '0;
            err     <= start_err;
            neg_q   <= signed_op && (data_dividend[WIDTH-1] ^ data_divisor[WIDTH-1]);
            neg_r   <= signed_op && data_dividend[WIDTH-1];
          end
        end
        RUN: begin
          if (!err) begin
            q_reg   <= {q_reg[WIDTH-2:0], trial_ok};
            acc_reg <= trial_ok ? diff : acc_sh[WIDTH-1:0];
            cnt     <= cnt + 1'b1;
          end
        end
        DONE: begin
          data_resultRDY <= 1'b1;
          if (err) begin
            data_quotient  <= '0;
            data_remainder <= '0;
            data_exception <= 1'b1;
          end else begin
            // Truncating division: quotient sign from the operand signs,
            // remainder sign from the dividend.
            data_quotient  <= neg_q ? -q_reg   : q_reg;
            data_remainder <= neg_r ? -acc_reg : acc_reg;
            data_exception <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_thirtytwo_bit_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_thirtytwo_bit_divider
// Purpose  : Self-checking bench for thirtytwo_bit_divider. A behavioural
//            model built on plain integer division predicts the outputs on
//            every cycle. Directed cases use literal expectations, and a
//            random phase covers operand corner cases and busy-time pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_thirtytwo_bit_divider;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_div = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] data_dividend = '0;
  logic [31:0] data_divisor = '0;
  logic [31:0] data_quotient, data_remainder;
  logic        data_exception, data_resultRDY, busy;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  thirtytwo_bit_divider #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_div       (ctrl_div),
    .signed_op      (signed_op),
    .data_dividend  (data_dividend),
    .data_divisor   (data_divisor),
    .data_quotient  (data_quotient),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        e;
    int          lat;   // edges from the sampling edge to the writing edge
  } res_t;

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    res_t   res;
    longint sa, sb;
    res.e   = 1'b0;
    res.lat = 33;
    if (b == 32'd0) begin
      res.q = '0; res.r = '0; res.e = 1'b1; res.lat = 2;
    end else if (!s) begin
      res.q = a / b;
      res.r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
`ifdef DIV_OVERFLOW_EXC_EN
      res.q = '0; res.r = '0; res.e = 1'b1; res.lat = 2;
`else
      res.q = 32'h8000_0000; res.r = '0;
`endif
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      res.q = 32'(sa / sb);
      res.r = 32'(sa % sb);
    end
    return res;
  endfunction

  // Cycle-level model: accepts a start only when nothing is pending, holds
  // results until the next completion and pulses ready for one cycle.
  logic [31:0] m_q, m_r, p_q, p_r;
  logic        m_e, p_e, m_rdy, m_busy;
  int          m_cnt;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_q <= '0; m_r <= '0; m_e <= 1'b0; m_rdy <= 1'b0; m_busy <= 1'b0; m_cnt <= 0;
      p_q <= '0; p_r <= '0; p_e <= 1'b0;
    end else begin
      m_rdy <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 1) begin
          m_q <= p_q; m_r <= p_r; m_e <= p_e; m_rdy <= 1'b1; m_busy <= 1'b0;
        end
        m_cnt <= m_cnt - 1;
      end else if (ctrl_div) begin
        p_q    <= model(data_dividend, data_divisor, signed_op).q;
        p_r    <= model(data_dividend, data_divisor, signed_op).r;
        p_e    <= model(data_dividend, data_divisor, signed_op).e;
        m_cnt  <= model(data_dividend, data_divisor, signed_op).lat;
        m_busy <= 1'b1;
      end
    end
  end

  // Compare process: every cycle once out of initial reset
  always @(negedge clock) begin
    if (chk_en) begin
      tests++;
      if (data_resultRDY !== m_rdy || busy !== m_busy || data_quotient !== m_q ||
          data_remainder !== m_r || data_exception !== m_e) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t got rdy=%b busy=%b q=%h r=%h e=%b expected rdy=%b busy=%b q=%h r=%h e=%b",
                 $time, data_resultRDY, busy, data_quotient, data_remainder, data_exception,
                 m_rdy, m_busy, m_q, m_r, m_e);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Call at a negedge; returns at the negedge after the sampling edge.
  task automatic start(input logic [31:0] a, input logic [31:0] b, input logic s);
    ctrl_div = 1'b1; data_dividend = a; data_divisor = b; signed_op = s;
    @(negedge clock);
    ctrl_div = 1'b0;
  endtask

  // Number of negedges until ready is seen, -1 if the bound expires.
  task automatic wait_ready(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic rnd_ops(output logic [31:0] a, output logic [31:0] b, output logic s);
    int mode;
    mode = int'($urandom_range(0, 7));
    s = 1'($urandom_range(0, 1));
    a = $urandom;
    b = $urandom;
    case (mode)
      0: b = '0;
      1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      2: b = 32'($urandom_range(1, 15));
      3: begin a = 32'($urandom_range(0, 100)); b = 32'($urandom_range(101, 1000)); end
      4: b = 32'hFFFF_FFFF;
      default: ;
    endcase
  endtask

  // ---------------- directed table ----------------
  localparam int ND = 9;
  logic [31:0] t_a [ND] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000};
  logic [31:0] t_b [ND] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd1, 32'd1,
                            32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF};
  logic        t_s [ND] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] t_q [ND] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'h7FFF_FFFF, 32'd0, 32'd0,
`ifdef DIV_OVERFLOW_EXC_EN
                            32'd0};
`else
                            32'h8000_0000};
`endif
  logic [31:0] t_r [ND] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0,
                            32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0};
`ifdef DIV_OVERFLOW_EXC_EN
  logic        t_e [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  int          t_l [ND] = '{33, 33, 33, 33, 33, 33, 33, 2, 2};
`else
  logic        t_e [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  int          t_l [ND] = '{33, 33, 33, 33, 33, 33, 33, 2, 33};
`endif

  initial begin
    res_t        mr;
    int          n;
    logic [31:0] ra, rb;
    logic        rs;

    // Reset state
    repeat (2) @(negedge clock);
    chk("reset_q", data_quotient, 32'd0);
    chk("reset_r", data_remainder, 32'd0);
    chk("reset_flags", {29'd0, data_exception, data_resultRDY, busy}, 32'd0);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Pin the model to hand-computed values
    for (int i = 0; i < ND; i++) begin
      mr = model(t_a[i], t_b[i], t_s[i]);
      chk($sformatf("model_%0d", i), {mr.q, mr.r, 31'(mr.lat), mr.e} == {t_q[i], t_r[i], 31'(t_l[i]), t_e[i]} ? 32'd1 : 32'd0, 32'd1);
    end

    // Directed table against the DUT
    @(negedge clock);
    for (int i = 0; i < ND; i++) begin
      start(t_a[i], t_b[i], t_s[i]);
      wait_ready(n);
      chk($sformatf("dir%0d_latency", i), 32'(n), 32'(t_l[i]));
      chk($sformatf("dir%0d_q", i), data_quotient, t_q[i]);
      chk($sformatf("dir%0d_r", i), data_remainder, t_r[i]);
      chk($sformatf("dir%0d_e", i), {31'd0, data_exception}, {31'd0, t_e[i]});
      @(negedge clock);
      chk($sformatf("dir%0d_after", i), {30'd0, data_resultRDY, busy}, 32'd0);
    end

    // Start pulse while busy is ignored; start in the ready cycle is accepted
    start(32'd100, 32'd7, 1'b0);
    repeat (9) @(negedge clock);
    start(32'd9, 32'd3, 1'b0);
    wait_ready(n);
    chk("ignore_latency", 32'(n), 32'd23);
    chk("ignore_q", data_quotient, 32'd14);
    chk("ignore_r", data_remainder, 32'd2);
    start(32'd9, 32'd3, 1'b0);
    wait_ready(n);
    chk("rdy_accept_latency", 32'(n), 32'd33);
    chk("rdy_accept_q", data_quotient, 32'd3);
    chk("rdy_accept_r", data_remainder, 32'd0);

    // Asynchronous reset in mid-operation
    @(negedge clock);
    start(32'd100, 32'd7, 1'b0);
    repeat (14) @(negedge clock);
    @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_q", data_quotient, 32'd0);
    chk("abort_r", data_remainder, 32'd0);
    chk("abort_flags", {29'd0, data_exception, data_resultRDY, busy}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);   // compare process checks no stray ready
    start(32'd100, 32'd7, 1'b0);
    wait_ready(n);
    chk("post_reset_latency", 32'(n), 32'd33);
    chk("post_reset_q", data_quotient, 32'd14);
    chk("post_reset_r", data_remainder, 32'd2);

    // Random phase: pulses land both in idle and busy cycles
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        rnd_ops(ra, rb, rs);
        ctrl_div = 1'b1; data_dividend = ra; data_divisor = rb; signed_op = rs;
      end else begin
        ctrl_div = 1'b0;
      end
      @(negedge clock);
    end
    ctrl_div = 1'b0;
    repeat (40) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
